// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
//   Shared definitions for the sequential shift-add multiplier.
//   - state_t       : controller state encoding (IDLE, CALC, OUT_LO, OUT_HI)
//   - DEFAULT_WIDTH : default operand width (also the output bus width)
// ---------------------------------------------------------------------------
package mul_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    OUT_LO = 2'd2,
    OUT_HI = 2'd3
  } state_t;

endpackage : mul_pkg

// File: rtl/mul_datapath.sv
// ---------------------------------------------------------------------------
// mul_datapath
//   Shift-add datapath of the sequential multiplier: multiplicand register,
//   accumulator, multiplier/quotient register, adder and right shifter.
//   After WIDTH steps o_acc holds the product high half and o_mq the low half.
//
// Ports
//   clk     in   clock, all state changes on the rising edge
//   rst     in   synchronous active-high reset, clears every register
//   i_load  in   capture i_a/i_b and clear the accumulator
//   i_step  in   perform one add-and-shift iteration
//   i_a     in   multiplicand
//   i_b     in   multiplier
//   o_acc   out  accumulator (product high half when finished)
//   o_mq    out  multiplier/quotient register (product low half when finished)
// ---------------------------------------------------------------------------
module mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_mq
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mq;

  logic [WIDTH-1:0] w_addend;
  // {carry, acc} after the conditional add; bit WIDTH is the adder carry.
  logic [WIDTH:0]   w_sum;

  assign w_addend = r_mq[0] ? r_mcand : '0;
  assign w_sum    = {1'b0, r_acc} + {1'b0, w_addend};

  // The right shift of {carry, acc, mq} moves the carry into the accumulator
  // MSB and the accumulator LSB into the mq MSB. A zero is shifted in above
  // the carry, so the carry never needs to persist between iterations.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_acc   <= '0;
      r_mq    <= '0;
    end else if (i_load) begin
      r_mcand <= i_a;
      r_acc   <= '0;
      r_mq    <= i_b;
    end else if (i_step) begin
      r_acc <= w_sum[WIDTH:1];
      r_mq  <= {w_sum[0], r_mq[WIDTH-1:1]};
    end
  end

  assign o_acc = r_acc;
  assign o_mq  = r_mq;

endmodule : mul_datapath

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//   Sequential unsigned shift-add multiplier. A start in IDLE captures the
//   operands, WIDTH iterations compute the 2*WIDTH-bit product, then the
//   product is emitted as two load beats (low half, then high half) for a
//   downstream WIDTH-bit register.
//
// Ports
//   clk       in   clock
//   rst       in   synchronous active-high reset (wins over start)
//   start     in   request, only honoured in IDLE
//   a         in   multiplicand, captured with an accepted start
//   b         in   multiplier, captured with an accepted start
//   busy      out  high while a product is being computed or emitted
//   done      out  one-cycle pulse together with the high-half beat
//   out_data  out  product half for the downstream register
//   out_load  out  one-cycle strobe qualifying out_data
//   out_sel   out  0 = low half, 1 = high half (valid with out_load)
//
// All outputs are registered from the current state, so each output lags
// the state that produces it by one cycle: a start accepted at edge T gives
// the low beat after T+WIDTH+1, the high beat and done after T+WIDTH+2, and
// busy falls after T+WIDTH+3.
// ---------------------------------------------------------------------------
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_data,
  output logic             out_load,
  output logic             out_sel
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_load;
  logic             r_sel;
  logic [WIDTH-1:0] r_data;

  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_acc;
  logic [WIDTH-1:0] w_mq;

  // Datapath controls decode straight from the state; reset is handled
  // inside the datapath with the same priority over load/step.
  assign w_load = (r_state == IDLE) && start;
  assign w_step = (r_state == CALC);

  mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_a    (a),
    .i_b    (b),
    .o_acc  (w_acc),
    .o_mq   (w_mq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_load  <= 1'b0;
      r_sel   <= 1'b0;
      r_data  <= '0;
    end else begin
      // Strobes default low so each beat lasts exactly one cycle.
      r_busy <= (r_state != IDLE);
      r_done <= 1'b0;
      r_load <= 1'b0;
      r_sel  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_count <= CNT_W'(WIDTH);
            r_state <= CALC;
          end
        end
        CALC: begin
          r_count <= r_count - CNT_W'(1);
          // Last iteration: the counter reaches zero on this edge.
          if (r_count == CNT_W'(1)) begin
            r_state <= OUT_LO;
          end
        end
        OUT_LO: begin
          r_data  <= w_mq;
          r_load  <= 1'b1;
          r_sel   <= 1'b0;
          r_state <= OUT_HI;
        end
        OUT_HI: begin
          r_data  <= w_acc;
          r_load  <= 1'b1;
          r_sel   <= 1'b1;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign out_data = r_data;
  assign out_load = r_load;
  assign out_sel  = r_sel;

endmodule : seq_multiplier

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential unsigned shift-add multiplier that feeds the 16-bit `register` stage. It accepts two `WIDTH`-bit operands on a single-cycle start, computes the 2·`WIDTH`-bit product in `WIDTH` iterations, then drives the product onto the register input bus as two successive beats, low half first. Each beat carries a one-cycle load strobe for the downstream register. It is the arithmetic source for result registers that the ALU cannot fill in one cycle.

## Interface
- `WIDTH`, 16, operand width and output bus width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `a`  in  `WIDTH`  multiplicand; captured with `start`.
- `b`  in  `WIDTH`  multiplier; captured with `start`.
- `busy`  out  1  high in CALC, OUT_LO and OUT_HI.
- `done`  out  1  one-cycle pulse, coincident with the high-half beat.
- `out_data`  out  `WIDTH`  product half driven to the downstream register `in`.
- `out_load`  out  1  one-cycle strobe; downstream register captures `out_data` on it.
- `out_sel`  out  1  0 = low half, 1 = high half; valid while `out_load` is high.

## Operation
- States: IDLE, CALC, OUT_LO, OUT_HI.
- IDLE with `start` = 1: latch `a` into `mcand` and `b` into `mq`, clear `acc` (`WIDTH` bits) and `carry`, load the iteration counter with `WIDTH`, go to CALC.
- CALC, each cycle:
  - If `mq[0]` is set, form `{carry, acc} = acc + mcand` (`WIDTH`+1 bits); otherwise `{carry, acc} = {0, acc}`.
  - Shift `{carry, acc, mq}` right by 1.
  - Decrement the counter. When the counter reaches 0 after the decrement, go to OUT_LO.
- After CALC, `acc` holds the product high half and `mq` holds the low half.
- OUT_LO: `out_data` = `mq`, `out_load` = 1, `out_sel` = 0; go to OUT_HI.
- OUT_HI: `out_data` = `acc`, `out_load` = 1, `out_sel` = 1, `done` = 1; go to IDLE.
- Arithmetic is unsigned. No overflow is possible: the full product fits in 2·`WIDTH` bits.
- `start` is ignored outside IDLE. The operand inputs are ignored except in the cycle `start` is accepted.
- The counter is `$clog2(WIDTH)+1` bits wide.

## Timing
- All outputs are registered.
- Reset values: `busy` = 0, `done` = 0, `out_load` = 0, `out_sel` = 0, `out_data` = 0; state is IDLE and all datapath registers are 0.
- With `start` accepted at edge T:
  - CALC occupies T+1 … T+`WIDTH`.
  - Low-half beat is visible after edge T+`WIDTH`+1.
  - High-half beat and `done` are visible after edge T+`WIDTH`+2.
  - `busy` falls after edge T+`WIDTH`+3.
- Total latency from `start` to `done` is `WIDTH`+2 cycles, i.e. 18 at the default width.
- Back-to-back operation: `start` is accepted in the first IDLE cycle after OUT_HI. Throughput is one product per `WIDTH`+3 cycles.
- `out_load` is never high for two consecutive cycles with the same `out_sel` value.
- `out_data` holds its last driven value while in IDLE and CALC.
- Reset asserted in any state returns to IDLE on the next edge with all outputs at their reset values. No partial beats or strobes are emitted afterwards.
- `rst` has priority over `start` when both are high in the same cycle.

## Structure
- Shared package `mul_pkg`: state encoding (2-bit enum: IDLE=0, CALC=1, OUT_LO=2, OUT_HI=3) and the default `WIDTH` constant.
- One sub-module, `mul_datapath`, holds `acc`, `mq`, `mcand`, `carry`, the adder and the shifter. The top level holds the FSM and the counter.
- The downstream `register` is instantiated by the integrator, not inside this block.

## Test plan
- `a` = 0x0003, `b` = 0x0005, pulse `start` → low beat `out_data` = 0x000F with `out_sel` = 0, then high beat 0x0000 with `out_sel` = 1 and `done`; `done` arrives exactly 18 cycles after `start`.
- `a` = 0xFFFF, `b` = 0xFFFF → low beat 0x0001, high beat 0xFFFE (the carry path is exercised).
- `a` = 0x0000, `b` = 0xABCD → both beats 0x0000; `busy` is high for exactly 18 cycles.
- Start 0x1234 × 0x0010, then pulse `start` with `a` = `b` = 0xFFFF at cycle 5 → request ignored; beats are 0x2340, then 0x0001.
- Assert `rst` at cycle 8 of CALC → next cycle `busy` = 0 and no `out_load` occurs; a fresh `start` with 0x0002 × 0x0003 yields 0x0006 / 0x0000.
- Hold `start` high continuously with 0x00FF × 0x0100 → products repeat every 19 cycles (0xFF00 / 0x0000); each downstream register capture matches its `out_sel`.
